// File: rtl/uart_rx_if.sv
// Receive-side result bundle of the 8N1 UART receiver: byte, strobes and busy flag.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       rx_busy;

  modport master (
    output rx_data,
    output rx_done,
    output frame_err,
    output parity_err,
    output rx_busy
  );

  modport slave (
    input rx_data,
    input rx_done,
    input frame_err,
    input parity_err,
    input rx_busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling rs232_rx at mid-bit; results leave through uart_rx_if.
// Optional even-parity bit between data and stop enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned BAUD_END = 107,
  parameter int unsigned BAUD_MID = 53
) (
  input  logic      clk50M,
  input  logic      rst_n,
  input  logic      rs232_rx,
  uart_rx_if.master rx_if
);

  localparam logic [15:0] END_CNT = 16'(BAUD_END);
  localparam logic [15:0] MID_CNT = 16'(BAUD_MID);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state, state_nxt;
  logic        s1, s2, s3;
  logic [15:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [7:0]  rx_data_q, data_nxt;
  logic        done_q, done_nxt;
  logic        ferr_q, ferr_nxt;
  logic        fall, mid, wrap;
`ifdef UART_RX_PARITY_EN
  logic        par_bad, par_bad_nxt;
  logic        perr_q, perr_nxt;
`endif

  // rs232_rx is asynchronous: only s2/s3 ever reach the FSM
  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rs232_rx;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;
  assign mid  = (baud_cnt == MID_CNT);
  assign wrap = (baud_cnt == END_CNT);

  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      shift     <= shift_nxt;
      rx_data_q <= data_nxt;
      done_q    <= done_nxt;
      ferr_q    <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad   <= par_bad_nxt;
      perr_q    <= perr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = rx_data_q;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    perr_nxt    = 1'b0;
`endif

    if (state != IDLE) begin
      baud_nxt = wrap ? '0 : baud_cnt + 16'd1;
    end

    case (state)
      IDLE: begin
        baud_nxt = '0;
        bit_nxt  = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = 1'b0;
`endif
        if (fall) state_nxt = START;
      end

      START: begin
        if (mid && s2) begin
          state_nxt = IDLE;
          baud_nxt  = '0;
        end else if (wrap) begin
          state_nxt = DATA;
        end
      end

      DATA: begin
        if (mid) shift_nxt = {s2, shift[7:1]};
        if (wrap) begin
          if (bit_cnt == 3'd7) begin
            bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = bit_cnt + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid) par_bad_nxt = (s2 != (^shift));
        if (wrap) state_nxt = STOP;
      end
`endif

      STOP: begin
        // leave at mid stop bit so a back-to-back start edge is not missed
        if (mid) begin
          state_nxt = IDLE;
          baud_nxt  = '0;
          if (!s2) begin
            ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_bad) begin
            perr_nxt = 1'b1;
`endif
          end else begin
            data_nxt = shift;
            done_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
      end
    endcase
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_done   = done_q;
  assign rx_if.frame_err = ferr_q;
  assign rx_if.rx_busy   = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = perr_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the serial transmitter on the FPGA UART-to-XINTF bridge.
- Samples the asynchronous rs232_rx line at mid-bit and delivers each byte as rx_data with a one-cycle rx_done strobe toward the XINTF-side logic.
- Flags framing errors on the same strobe timing.
- Baud timing uses the same count-to-BAUD_END scheme as the transmit side, so both directions share one baud setting.

Parameters:
- BAUD_END, 107: last value of the bit-period counter; period = BAUD_END+1 clocks (108 → 460800 bps at 50 MHz).
- BAUD_MID, 53: counter value at which a bit is sampled (≈ BAUD_END/2).

Ports:
- clk50M  input  1  system clock, 50 MHz.
- rst_n  input  1  reset; synchronous, active-low.
- rs232_rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last correctly received byte.
- rx_done  output  1  one-cycle strobe; rx_data is valid and updated.
- frame_err  output  1  one-cycle strobe; stop bit was sampled low.
- parity_err  output  1  one-cycle strobe; parity mismatch (constant 0 unless UART_RX_PARITY_EN).
- rx_busy  output  1  high while a frame is being received (state ≠ IDLE).

Behaviour:
- Reset, synchronous with rst_n low at a clk50M edge:
  - rx_data=0, rx_done=0, frame_err=0, parity_err=0, rx_busy=0.
  - Synchronizer flops set to 1, state=IDLE, counters=0.
  - Reset mid-frame abandons the frame with no strobes.
- Input sync: rs232_rx passes through 3 flops (s1,s2,s3). All logic uses s2; the falling edge is s3=1 & s2=0.
- States:
  - IDLE: wait for a falling edge, then go to START with baud_cnt=0.
  - START: at baud_cnt==BAUD_MID, if s2=1 it is a false start (glitch); return to IDLE with no strobe. If s2=0, continue.
  - DATA: 8 bits, LSB first, each sampled at baud_cnt==BAUD_MID into a shift register; bit_cnt runs 0..7.
  - STOP: sample at BAUD_MID, then return to IDLE immediately (mid stop bit) so a back-to-back start edge is caught.
- Counters:
  - baud_cnt is 16-bit; it increments while state≠IDLE, wraps to 0 at BAUD_END, and is held at 0 in IDLE.
  - State advances START→DATA, DATA bit7→STOP, and so on at the baud_cnt wrap (end of bit period).
  - Exception: STOP→IDLE happens at the BAUD_MID sample.
- Stop-sample results:
  - s2=1: rx_data <= shift register; rx_done=1 for exactly the next cycle.
  - s2=0: frame_err=1 for one cycle; rx_data keeps its old value; rx_done stays 0.
- rx_done and frame_err are never high together. All strobes return to 0 after one cycle.
- Latency: rx_done rises ≈ 9.5 bit periods + 3 clocks after the line falling edge, i.e. 2 sync clocks + 9×108 + 54 + 1 clocks at defaults.
- A line held low (break) yields a frame_err, then re-arms only after the line returns high and falls again.
- rs232_rx changes at any time are tolerated; no metastable value reaches the FSM.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, expecting an even-parity bit sampled at BAUD_MID.
  - On mismatch, parity_err=1 for one cycle coincident with the stop-sample strobe. rx_data is still not updated, and rx_done=0.
  - A frame error takes priority: only frame_err is asserted.
- Undefined: 8N1 only, no PARITY state; parity_err tied 0.

Test Plan:
- Frame 0x55 at 108 clk/bit, 1 stop bit → rx_data=0x55, a single rx_done pulse, frame_err=0, rx_busy falls with the pulse.
- Back-to-back 0xA5 then 0x3C, stop bit exactly 1 period → two rx_done pulses; rx_data=0xA5 then 0x3C, none missed.
- 20-clock low glitch on idle line → no rx_done or frame_err; rx_busy high ≈ 56 clocks then 0.
- Receive 0x12, then frame 0xFF with stop bit driven 0 → frame_err pulse, rx_done=0, rx_data stays 0x12.
- rst_n low for 1 clock during data bit 3 of a frame → all outputs 0 the next cycle; a following clean 0x81 is received correctly.
- (UART_RX_PARITY_EN) 0x07 sent with parity bit 0 → parity_err pulse, rx_done=0. 0x07 with parity 1 → rx_data=0x07, rx_done pulse.
